// File: rtl/xb_info_scan.sv
// Bus master that walks the XB_INFO indirect CSR: writes the pointer, checks the
// 4-byte signature, reads NUM, then copies up to MAX_ENT info bytes into a local buffer.
module xb_info_scan #(
  parameter logic [7:0] XB_INFO_ADDR = 8'hFF,
  parameter logic [7:0] VALID_ADDR   = 8'hFC,
  parameter logic [7:0] VALID_VAL0   = 8'h88,
  parameter logic [7:0] VALID_VAL1   = 8'h76,
  parameter logic [7:0] VALID_VAL2   = 8'h82,
  parameter logic [7:0] VALID_VAL3   = 8'h56,
  parameter int         MAX_ENT      = 16,
  localparam int        IDX_W        = $clog2(MAX_ENT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic             dm_sel,
  output logic [7:0]       ramadr,
  output logic             ramwe,
  output logic             ramre,
  output logic [7:0]       dbus_out,
  input  logic [7:0]       dbus_in,
  input  logic             out_en,
  output logic             busy,
  output logic             done,
  output logic             present,
  output logic             overflow,
  output logic [7:0]       num_entries,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PTR,
    S_RD_SIG,
    S_WR_ZERO,
    S_RD_NUM,
    S_RD_ENT,
    S_DONE
  } state_t;

  localparam logic [8:0] MAX_ENT_W = 9'(MAX_ENT);

  state_t           state_q, state_d;
  logic [1:0]       sig_k_q, sig_k_d;
  logic [IDX_W-1:0] ent_i_q, ent_i_d;
  logic [8:0]       ent_cnt_q, ent_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             present_q, present_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       num_q, num_d;
  logic [7:0]       buf_q [MAX_ENT];

  logic             buf_we;
  logic             fin_ok, fin_fail;
  logic [7:0]       sig_exp;
  logic             in_scan, access, is_wr, is_rd;
  logic [8:0]       rd_lim;

  // Strobes are pure decode of the state register, so an async reset drops them at once.
  assign in_scan  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign access   = in_scan && bus_gnt;
  assign is_wr    = (state_q == S_WR_PTR) || (state_q == S_WR_ZERO);
  assign is_rd    = in_scan && !is_wr;
  assign bus_req  = in_scan;
  assign ramwe    = access && is_wr;
  assign ramre    = access && is_rd;
  assign dm_sel   = ramwe | ramre;
  assign ramadr   = dm_sel ? XB_INFO_ADDR : 8'h00;
  assign dbus_out = (ramwe && (state_q == S_WR_PTR)) ? VALID_ADDR : 8'h00;

  always_comb begin
    case (sig_k_q)
      2'd0:    sig_exp = VALID_VAL0;
      2'd1:    sig_exp = VALID_VAL1;
      2'd2:    sig_exp = VALID_VAL2;
      default: sig_exp = VALID_VAL3;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    sig_k_d    = sig_k_q;
    ent_i_d    = ent_i_q;
    ent_cnt_d  = ent_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    present_d  = present_q;
    overflow_d = overflow_q;
    num_d      = num_q;
    buf_we     = 1'b0;
    fin_ok     = 1'b0;
    fin_fail   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_WR_PTR;
          busy_d     = 1'b1;
          present_d  = 1'b0;
          overflow_d = 1'b0;
          num_d      = 8'h00;
          sig_k_d    = 2'd0;
          ent_i_d    = '0;
        end
      end
      S_WR_PTR: begin
        if (bus_gnt) begin
          state_d = S_RD_SIG;
          sig_k_d = 2'd0;
        end
      end
      S_RD_SIG: begin
        if (bus_gnt) begin
          if (!out_en || (dbus_in != sig_exp)) fin_fail = 1'b1;
          else if (sig_k_q == 2'd3)            state_d  = S_WR_ZERO;
          else                                 sig_k_d  = sig_k_q + 2'd1;
        end
      end
      S_WR_ZERO: begin
        if (bus_gnt) state_d = S_RD_NUM;
      end
      S_RD_NUM: begin
        if (bus_gnt) begin
          if (!out_en) begin
            fin_fail = 1'b1;
          end else begin
            num_d      = dbus_in;
            overflow_d = {1'b0, dbus_in} > MAX_ENT_W;
            ent_cnt_d  = overflow_d ? MAX_ENT_W : {1'b0, dbus_in};
            ent_i_d    = '0;
            if (dbus_in == 8'h00) fin_ok  = 1'b1;
            else                  state_d = S_RD_ENT;
          end
        end
      end
      S_RD_ENT: begin
        if (bus_gnt) begin
          if (!out_en) begin
            fin_fail = 1'b1;
          end else begin
            buf_we = 1'b1;
            if (9'(ent_i_q) == (ent_cnt_q - 9'd1)) fin_ok  = 1'b1;
            else                                   ent_i_d = ent_i_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin_ok || fin_fail) begin
      state_d   = S_DONE;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      present_d = fin_ok;
    end
    // A failed scan reports nothing it may have captured on the way.
    if (fin_fail) begin
      num_d      = 8'h00;
      overflow_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the info buffer is in the reset domain, so it reads as zeros until a scan refills it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sig_k_q    <= 2'd0;
      ent_i_q    <= '0;
      ent_cnt_q  <= 9'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      present_q  <= 1'b0;
      overflow_q <= 1'b0;
      num_q      <= 8'h00;
      for (int i = 0; i < MAX_ENT; i++) buf_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      sig_k_q    <= sig_k_d;
      ent_i_q    <= ent_i_d;
      ent_cnt_q  <= ent_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      present_q  <= present_d;
      overflow_q <= overflow_d;
      num_q      <= num_d;
      if (buf_we) buf_q[ent_i_q] <= dbus_in;
    end
  end

  always_comb begin
    rd_lim  = ({1'b0, num_q} > MAX_ENT_W) ? MAX_ENT_W : {1'b0, num_q};
    rd_data = (9'(rd_idx) < rd_lim) ? buf_q[rd_idx] : 8'h00;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign present     = present_q;
  assign overflow    = overflow_q;
  assign num_entries = num_q;

endmodule

// File: tb/tb_xb_info_scan.sv
// Bench for xb_info_scan: a behavioural XB_INFO target answers reads from a table,
// and every bus access is logged and checked against an expected-access scoreboard.
module tb_xb_info_scan;

  localparam int MAX_ENT = 16;
  localparam int IDX_W   = $clog2(MAX_ENT);

  typedef struct packed {
    logic       we;
    logic [7:0] data;
  } acc_t;

  logic             clk, rst, start, bus_gnt, out_en;
  logic             bus_req, dm_sel, ramwe, ramre, busy, done, present, overflow;
  logic [7:0]       ramadr, dbus_out, dbus_in, num_entries, rd_data;
  logic [IDX_W-1:0] rd_idx;

  int   n_cmp = 0;
  int   n_mis = 0;
  acc_t exp_q[$];
  acc_t obs_q[$];
  logic [7:0] resp_tbl [0:63];
  int   rd_cnt    = 0;
  int   rd_base   = 0;
  int   gnt_viol  = 0;
  int   addr_viol = 0;
  logic [5:0] resp_idx;

  // The target returns the next table byte for every read of the current scan.
  assign resp_idx = 6'(rd_cnt - rd_base);
  assign dbus_in  = resp_tbl[resp_idx];

  xb_info_scan #(.MAX_ENT(MAX_ENT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .dm_sel(dm_sel), .ramadr(ramadr),
    .ramwe(ramwe), .ramre(ramre), .dbus_out(dbus_out), .dbus_in(dbus_in),
    .out_en(out_en), .busy(busy), .done(done), .present(present),
    .overflow(overflow), .num_entries(num_entries), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    acc_t a;
    if (ramwe || ramre) begin
      a.we   = ramwe;
      a.data = ramwe ? dbus_out : dbus_in;
      obs_q.push_back(a);
      if (!bus_gnt) gnt_viol++;
      if (ramadr !== 8'hFF || dm_sel !== 1'b1 || (ramwe && ramre)) addr_viol++;
      if (ramre) rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic set_resp(input logic [7:0] num, input logic [7:0] base);
    resp_tbl[0] = 8'h88;
    resp_tbl[1] = 8'h76;
    resp_tbl[2] = 8'h82;
    resp_tbl[3] = 8'h56;
    resp_tbl[4] = num;
    for (int i = 0; i < 40; i++) resp_tbl[5+i] = base + 8'(i);
  endtask

  task automatic push_acc(input logic we, input logic [7:0] data);
    acc_t a;
    a.we   = we;
    a.data = data;
    exp_q.push_back(a);
  endtask

  task automatic push_exp_full(input int n_ent);
    push_acc(1'b1, 8'hFC);
    for (int i = 0; i < 4; i++) push_acc(1'b0, resp_tbl[i]);
    push_acc(1'b1, 8'h00);
    push_acc(1'b0, resp_tbl[4]);
    for (int i = 0; i < n_ent; i++) push_acc(1'b0, resp_tbl[5+i]);
  endtask

  task automatic push_exp_head(input int n_rd);
    push_acc(1'b1, 8'hFC);
    for (int i = 0; i < n_rd; i++) push_acc(1'b0, resp_tbl[i]);
  endtask

  task automatic compare_accesses(input string tag);
    acc_t e, o;
    int   idx;
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_mis++;
      $display("FAIL %s access_count: got %0d want %0d", tag, obs_q.size(), exp_q.size());
    end
    idx = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL %s access[%0d]: got we=%0b data=%02h want we=%0b data=%02h",
                 tag, idx, o.we, o.data, e.we, e.data);
      end
      idx++;
    end
    exp_q.delete();
    obs_q.delete();
    n_cmp++;
    if (gnt_viol !== 0 || addr_viol !== 0) begin
      n_mis++;
      $display("FAIL %s bus_rules: got gnt_viol=%0d addr_viol=%0d want 0/0", tag, gnt_viol, addr_viol);
    end
  endtask

  // Pulses start, optionally toggles grant (high on odd cycles) and an extra start at
  // cycle extra_start; returns the cycle (counted from the start cycle) where done is seen.
  task automatic run_scan(input string tag, input bit toggle, input int extra_start,
                          output int done_cyc);
    rd_base = rd_cnt;
    @(negedge clk);
    start   = 1'b1;
    bus_gnt = 1'b1;
    done_cyc = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = (k == extra_start);
      if (k == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_mis++;
          $display("FAIL %s busy_after_start: got %0b want 1", tag, busy);
        end
      end
      if (done === 1'b1) begin
        done_cyc = k;
        break;
      end
      bus_gnt = toggle ? k[0] : 1'b1;
    end
    start   = 1'b0;
    bus_gnt = 1'b1;
    n_cmp++;
    if (done_cyc < 0) begin
      n_mis++;
      $display("FAIL %s done_timeout: got no done want done within 200 cycles", tag);
    end else if (busy !== 1'b0) begin
      n_mis++;
      $display("FAIL %s busy_at_done: got %0b want 0", tag, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_mis++;
      $display("FAIL %s done_pulse_width: got %0b want 0", tag, done);
    end
  endtask

  task automatic check_status(input string tag, input logic exp_present, input logic exp_ovf,
                              input logic [7:0] exp_num);
    n_cmp++;
    if ({present, overflow, num_entries} !== {exp_present, exp_ovf, exp_num}) begin
      n_mis++;
      $display("FAIL %s status: got present=%0b overflow=%0b num=%0d want %0b/%0b/%0d",
               tag, present, overflow, num_entries, exp_present, exp_ovf, exp_num);
    end
  endtask

  task automatic check_rd(input string tag, input int idx, input logic [7:0] exp);
    rd_idx = IDX_W'(idx);
    #1;
    n_cmp++;
    if (rd_data !== exp) begin
      n_mis++;
      $display("FAIL %s rd_data[%0d]: got %02h want %02h", tag, idx, rd_data, exp);
    end
  endtask

  task automatic test_reset();
    logic [52:0] obs;
    #1;
    obs = {bus_req, dm_sel, ramwe, ramre, busy, done, present, overflow,
           ramadr, dbus_out, num_entries, rd_data, 13'd0};
    n_cmp++;
    if (obs !== '0) begin
      n_mis++;
      $display("FAIL reset_in_rst: got %h want 0", obs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obs = {bus_req, dm_sel, ramwe, ramre, busy, done, present, overflow,
           ramadr, dbus_out, num_entries, rd_data, 13'd0};
    n_cmp++;
    if (obs !== '0) begin
      n_mis++;
      $display("FAIL reset_after_rst: got %h want 0", obs);
    end
  endtask

  task automatic test_basic(input string tag);
    int dc;
    set_resp(8'd3, 8'h11);
    push_exp_full(3);
    run_scan(tag, 1'b0, 0, dc);
    n_cmp++;
    if (dc !== 11) begin
      n_mis++;
      $display("FAIL %s done_cycle: got %0d want 11", tag, dc);
    end
    check_status(tag, 1'b1, 1'b0, 8'd3);
    check_rd(tag, 0, 8'h11);
    check_rd(tag, 1, 8'h12);
    check_rd(tag, 2, 8'h13);
    check_rd(tag, 3, 8'h00);
    compare_accesses(tag);
  endtask

  task automatic test_sig_mismatch();
    int dc;
    set_resp(8'd3, 8'h11);
    resp_tbl[1] = 8'h4C;
    push_exp_head(2);
    run_scan("sig_mismatch", 1'b0, 0, dc);
    n_cmp++;
    if (dc !== 4) begin
      n_mis++;
      $display("FAIL sig_mismatch done_cycle: got %0d want 4", dc);
    end
    check_status("sig_mismatch", 1'b0, 1'b0, 8'd0);
    repeat (5) @(negedge clk);
    compare_accesses("sig_mismatch");
  endtask

  task automatic test_absent();
    int dc;
    set_resp(8'd3, 8'h11);
    out_en = 1'b0;
    push_exp_head(1);
    run_scan("absent", 1'b0, 0, dc);
    n_cmp++;
    if (dc !== 3) begin
      n_mis++;
      $display("FAIL absent done_cycle: got %0d want 3", dc);
    end
    check_status("absent", 1'b0, 1'b0, 8'd0);
    repeat (5) @(negedge clk);
    out_en = 1'b1;
    compare_accesses("absent");
  endtask

  task automatic test_overflow();
    int dc;
    set_resp(8'd20, 8'hA0);
    push_exp_full(16);
    run_scan("overflow", 1'b0, 0, dc);
    n_cmp++;
    if (dc !== 24) begin
      n_mis++;
      $display("FAIL overflow done_cycle: got %0d want 24", dc);
    end
    check_status("overflow", 1'b1, 1'b1, 8'd20);
    check_rd("overflow", 0, 8'hA0);
    check_rd("overflow", 15, 8'hAF);
    compare_accesses("overflow");
  endtask

  task automatic test_gnt_toggle();
    int dc;
    set_resp(8'd3, 8'h11);
    push_exp_full(3);
    run_scan("gnt_toggle", 1'b1, 0, dc);
    // Ten accesses land on cycles 1,3,...,19, so done follows on cycle 20.
    n_cmp++;
    if (dc !== 20) begin
      n_mis++;
      $display("FAIL gnt_toggle done_cycle: got %0d want 20", dc);
    end
    check_status("gnt_toggle", 1'b1, 1'b0, 8'd3);
    check_rd("gnt_toggle", 1, 8'h12);
    check_rd("gnt_toggle", 2, 8'h13);
    compare_accesses("gnt_toggle");
  endtask

  task automatic test_start_busy();
    int dc;
    set_resp(8'd2, 8'h31);
    push_exp_full(2);
    run_scan("start_busy", 1'b0, 4, dc);
    n_cmp++;
    if (dc !== 10) begin
      n_mis++;
      $display("FAIL start_busy done_cycle: got %0d want 10", dc);
    end
    check_status("start_busy", 1'b1, 1'b0, 8'd2);
    check_rd("start_busy", 1, 8'h32);
    check_rd("start_busy", 2, 8'h00);
    compare_accesses("start_busy");
  endtask

  task automatic test_reset_mid();
    logic [19:0] obs;
    set_resp(8'd3, 8'h11);
    rd_base = rd_cnt;
    @(negedge clk);
    start   = 1'b1;
    bus_gnt = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if ({ramre, num_entries} !== {1'b1, 8'd3}) begin
      n_mis++;
      $display("FAIL reset_mid pre_rst: got ramre=%0b num=%0d want 1/3", ramre, num_entries);
    end
    rst = 1'b1;
    #1;
    obs = {bus_req, dm_sel, ramwe, ramre, busy, done, present, overflow, ramadr, 4'd0};
    n_cmp++;
    if ({obs, num_entries} !== '0) begin
      n_mis++;
      $display("FAIL reset_mid outputs: got %h num=%0d want 0", obs, num_entries);
    end
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    test_basic("rescan");
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    bus_gnt = 1'b1;
    out_en  = 1'b1;
    rd_idx  = '0;
    for (int i = 0; i < 64; i++) resp_tbl[i] = 8'h00;

    test_reset();
    test_basic("basic");
    test_sig_mismatch();
    test_absent();
    test_overflow();
    test_gnt_toggle();
    test_start_busy();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
